clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_cfg.sv | 50 +++++
 rtl/clk_div_prog.sv | 132 +++++++++++++
 tb/tb_clk_div_prog.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and default configuration for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStopping
  } state_e;

  localparam int unsigned DefW       = 16;
  localparam int unsigned DefDivRst  = 50;
  localparam int unsigned DefHighRst = 25;

endpackage

// File: rtl/clk_div_cfg.sv
// Clamps a requested divisor/high-time pair into a legal configuration and
// flags, one cycle later, any accepted load that needed clamping.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int unsigned W = DefW
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] div_i,
  input  logic [W-1:0] high_i,
  output logic [W-1:0] div_o,
  output logic [W-1:0] high_o,
  output logic         clamp_o
);

  logic clamped;
  logic clamp_q, clamp_d;

  always_comb begin
    clamped = 1'b0;
    div_o   = div_i;
    if (div_i < W'(2)) begin
      div_o   = W'(2);
      clamped = 1'b1;
    end
    // High time is bounded by the already-clamped divisor.
    high_o = high_i;
    if (high_i == '0) begin
      high_o  = W'(1);
      clamped = 1'b1;
    end else if (high_i >= div_o) begin
      high_o  = div_o - W'(1);
      clamped = 1'b1;
    end
    clamp_d = load_i && clamped;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clamp_q <= 1'b0;
    end else begin
      clamp_q <= clamp_d;
    end
  end

  assign clamp_o = clamp_q;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free reconfiguration at period
// boundaries and a graceful stop that always completes the current period.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned W        = DefW,
  parameter int unsigned DIV_RST  = DefDivRst,
  parameter int unsigned HIGH_RST = DefHighRst
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         LOAD,
  input  logic [W-1:0] DIV_IN,
  input  logic [W-1:0] HIGH_IN,
  output logic         CLK_OUT,
  output logic         TICK,
  output logic         PEND,
  output logic         CLAMP,
  output logic         RUNNING
);

  if (DIV_RST < 2 || HIGH_RST < 1 || HIGH_RST >= DIV_RST) begin : gen_bad_rst_cfg
    $error("clk_div_prog: DIV_RST/HIGH_RST violate the clamp rules");
  end

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_act_q, div_act_d, high_act_q, high_act_d;
  logic [W-1:0] div_sh_q, div_sh_d, high_sh_q, high_sh_d;
  logic         pend_q, pend_d;
  logic         clk_out_q, clk_out_d;
  logic         tick_q, tick_d;
  logic [W-1:0] div_cl, high_cl;
  logic         boundary;
  logic         run_d;

  clk_div_cfg #(
    .W(W)
  ) u_cfg (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (LOAD),
    .div_i  (DIV_IN),
    .high_i (HIGH_IN),
    .div_o  (div_cl),
    .high_o (high_cl),
    .clamp_o(CLAMP)
  );

  assign boundary = (state_q != StIdle) && (cnt_q == div_act_q - W'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    high_act_d = high_act_q;
    div_sh_d   = div_sh_q;
    high_sh_d  = high_sh_q;
    pend_d     = pend_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (EN) state_d = StRun;
      end
      StRun, StStopping: begin
        if (boundary) begin
          cnt_d   = '0;
          state_d = EN ? StRun : StIdle;
        end else begin
          cnt_d   = cnt_q + W'(1);
          state_d = EN ? StRun : StStopping;
        end
      end
      default: state_d = StIdle;
    endcase

    if (boundary && pend_q) begin
      div_act_d  = div_sh_q;
      high_act_d = high_sh_q;
      pend_d     = 1'b0;
    end

    // A load in IDLE or in the boundary cycle lands directly in the next period.
    if (LOAD) begin
      div_sh_d  = div_cl;
      high_sh_d = high_cl;
      if (state_q == StIdle || boundary) begin
        div_act_d  = div_cl;
        high_act_d = high_cl;
        pend_d     = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end

    run_d     = (state_d != StIdle);
    clk_out_d = run_d && (cnt_d < high_act_d);
    tick_d    = run_d && (cnt_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_act_q  <= W'(DIV_RST);
      high_act_q <= W'(HIGH_RST);
      div_sh_q   <= W'(DIV_RST);
      high_sh_q  <= W'(HIGH_RST);
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      high_act_q <= high_act_d;
      div_sh_q   <= div_sh_d;
      high_sh_q  <= high_sh_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign CLK_OUT = clk_out_q;
  assign TICK    = tick_q;
  assign PEND    = pend_q;
  assign RUNNING = (state_q != StIdle);

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: stimulus queues expected (high, low) period shapes,
// a monitor measures each output period between TICKs and compares.
module tb_clk_div_prog;

  localparam int unsigned W = 16;

  logic         CLK = 1'b0;
  logic         RST, EN, LOAD;
  logic [W-1:0] DIV_IN, HIGH_IN;
  logic         CLK_OUT, TICK, PEND, CLAMP, RUNNING;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int unsigned hi;
    int unsigned lo;
  } per_t;

  per_t exp_q[$];

  always #5 CLK = ~CLK;

  clk_div_prog dut (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (EN),
    .LOAD   (LOAD),
    .DIV_IN (DIV_IN),
    .HIGH_IN(HIGH_IN),
    .CLK_OUT(CLK_OUT),
    .TICK   (TICK),
    .PEND   (PEND),
    .CLAMP  (CLAMP),
    .RUNNING(RUNNING)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int unsigned hi, input int unsigned lo, input int n);
    per_t p;
    p.hi = hi;
    p.lo = lo;
    for (int i = 0; i < n; i++) exp_q.push_back(p);
  endtask

  // Monitor: one period runs from a TICK to the next TICK or to leaving RUN.
  bit          in_per = 1'b0;
  bit          dip;
  int unsigned hi_c, lo_c;

  initial begin
    per_t p;
    forever begin
      @(negedge CLK);
      if (RST) begin
        in_per = 1'b0;
      end else begin
        if (in_per && (TICK || !RUNNING)) begin
          in_per = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected period", hi_c, 0);
          end else begin
            p = exp_q.pop_front();
            check("period high", hi_c, p.hi);
            check("period low", lo_c, p.lo);
            check("period shape", 32'(dip), 0);
          end
        end
        if (TICK) begin
          in_per = 1'b1;
          hi_c   = 0;
          lo_c   = 0;
          dip    = 1'b0;
        end
        if (in_per) begin
          if (CLK_OUT) begin
            if (lo_c != 0) dip = 1'b1;
            hi_c++;
          end else begin
            lo_c++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_tick(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      seen = TICK;
    end
    check({"tick ", tag}, 32'(seen), 1);
  endtask

  task automatic wait_idle(input string tag);
    bit idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      step();
      idle = !RUNNING;
    end
    check({"idle ", tag}, 32'(idle), 1);
  endtask

  task automatic do_load(input logic [W-1:0] d, input logic [W-1:0] h);
    LOAD    = 1'b1;
    DIV_IN  = d;
    HIGH_IN = h;
    step();
    LOAD    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; EN = 1'b0; LOAD = 1'b0; DIV_IN = '0; HIGH_IN = '0;
    steps(3);
    check("rst clk_out", CLK_OUT, 0);
    check("rst tick", TICK, 0);
    check("rst pend", PEND, 0);
    check("rst clamp", CLAMP, 0);
    check("rst running", RUNNING, 0);
    RST = 1'b0;
    step();
    check("idle running", RUNNING, 0);

    // Default 50/25, then a mid-period load of 7/3.
    push(25, 25, 3);
    EN = 1'b1;
    wait_tick("A");
    check("first period clk_out", CLK_OUT, 1);
    check("first period running", RUNNING, 1);
    wait_tick("B");
    wait_tick("C");
    steps(10);
    push(3, 4, 2);
    do_load(7, 3);
    check("mid load pend", PEND, 1);
    check("mid load clamp", CLAMP, 0);
    steps(38);
    check("pend held to boundary", PEND, 1);
    check("old period low at 49", CLK_OUT, 0);
    step();
    check("new config tick", TICK, 1);
    check("pend cleared", PEND, 0);

    // Clamp 1/0 -> 2/1.
    wait_tick("E");
    steps(2);
    push(1, 1, 1);
    do_load(1, 0);
    check("clamp 1/0 pulse", CLAMP, 1);
    check("clamp 1/0 pend", PEND, 1);
    step();
    check("clamp pulse width", CLAMP, 0);

    // Clamp 5/9 -> 5/4.
    wait_tick("F");
    push(4, 1, 2);
    do_load(5, 9);
    check("clamp 5/9 pulse", CLAMP, 1);
    check("clamp 5/9 pend", PEND, 1);
    step();
    check("5/4 tick", TICK, 1);
    check("5/4 pend cleared", PEND, 0);

    // Back to 50/25, then stop at counter 10.
    wait_tick("H");
    push(25, 25, 1);
    do_load(50, 25);
    check("50/25 no clamp", CLAMP, 0);
    wait_tick("I");
    steps(10);
    EN = 1'b0;
    step();
    check("stopping running", RUNNING, 1);
    steps(38);
    check("stopping at 49 running", RUNNING, 1);
    check("stopping at 49 low", CLK_OUT, 0);
    step();
    check("stopped running", RUNNING, 0);
    check("stopped clk_out", CLK_OUT, 0);
    check("stopped tick", TICK, 0);
    steps(5);
    check("idle quiet clk_out", CLK_OUT, 0);
    check("idle quiet tick", TICK, 0);

    // Load in IDLE goes straight to active.
    do_load(4, 2);
    check("idle load pend", PEND, 0);
    check("idle load clamp", CLAMP, 0);
    push(2, 2, 1);
    EN = 1'b1;
    wait_tick("J");
    EN = 1'b0;
    wait_idle("J");
    do_load(50, 25);

    // Stop then resume inside the same period.
    push(25, 25, 2);
    EN = 1'b1;
    wait_tick("K");
    steps(10);
    EN = 1'b0;
    steps(20);
    EN = 1'b1;
    check("resume running", RUNNING, 1);
    steps(19);
    step();
    check("seamless tick", TICK, 1);
    check("seamless running", RUNNING, 1);

    // Load in the boundary cycle, then reset mid-period.
    steps(49);
    push(3, 4, 1);
    do_load(7, 3);
    check("boundary load tick", TICK, 1);
    check("boundary load pend", PEND, 0);
    check("boundary load clamp", CLAMP, 0);
    wait_tick("N");
    steps(2);
    RST = 1'b1; EN = 1'b0; LOAD = 1'b1; DIV_IN = 1; HIGH_IN = 0;
    step();
    RST = 1'b0; LOAD = 1'b0;
    check("abort clk_out", CLK_OUT, 0);
    check("abort tick", TICK, 0);
    check("abort pend", PEND, 0);
    check("abort clamp", CLAMP, 0);
    check("abort running", RUNNING, 0);
    step();
    check("dropped load clamp", CLAMP, 0);
    push(25, 25, 1);
    EN = 1'b1;
    wait_tick("post reset");
    EN = 1'b0;
    wait_idle("post reset");
    steps(2);
    check("queue drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
